// File: rtl/leve2_pkg.sv
// leve2_pkg -- shared definitions for the LEVE2 decode/operand-read stage.
//
// Contents:
//   OP_*        RV opcode constants that carry an immediate
//   imm_fmt_e   immediate format selected by the opcode
//   imm_fmt()   opcode -> immediate format
//   imm_gen()   sign-extended immediate, always built at 64 bits; callers
//               keep the low xlen bits
package leve2_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [2:0] {
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J,
    FMT_NONE
  } imm_fmt_e;

  function automatic imm_fmt_e imm_fmt(input logic [6:0] opcode);
    imm_fmt_e fmt;
    case (opcode)
      OP_LOAD, OP_IMM, OP_IMM32, OP_JALR, OP_SYSTEM: fmt = FMT_I;
      OP_STORE:                                      fmt = FMT_S;
      OP_BRANCH:                                     fmt = FMT_B;
      OP_LUI, OP_AUIPC:                              fmt = FMT_U;
      OP_JAL:                                        fmt = FMT_J;
      default:                                       fmt = FMT_NONE;
    endcase
    return fmt;
  endfunction

  // Every format is sign-extended from instr[31]; for a 32-bit datapath the
  // upper word is cleared so the value is identical whichever slice is kept.
  function automatic logic [63:0] imm_gen(input logic [31:0] instr, input int xlen);
    logic [63:0] imm;
    case (imm_fmt(instr[6:0]))
      FMT_I:   imm = {{52{instr[31]}}, instr[31:20]};
      FMT_S:   imm = {{52{instr[31]}}, instr[31:25], instr[11:7]};
      FMT_B:   imm = {{51{instr[31]}}, instr[31], instr[7], instr[30:25],
                      instr[11:8], 1'b0};
      FMT_U:   imm = {{32{instr[31]}}, instr[31:12], 12'h000};
      FMT_J:   imm = {{43{instr[31]}}, instr[31], instr[19:12], instr[20],
                      instr[30:21], 1'b0};
      default: imm = 64'd0;
    endcase
    if (xlen == 32) imm[63:32] = 32'd0;
    return imm;
  endfunction

endpackage

// File: rtl/leve2_regfile.sv
// leve2_regfile -- integer register file for the LEVE2 decode stage.
//
// Ports:
//   CLK     in   clock, write on rising edge
//   we      in   write enable
//   waddr   in   write index (5 bits)
//   wdata   in   write data (XLEN)
//   raddr1  in   read port 1 index
//   rdata1  out  read port 1 data (asynchronous)
//   raddr2  in   read port 2 index
//   rdata2  out  read port 2 data (asynchronous)
//
// x0 and indices >= NUM_REG read as zero and are never written. The array is
// not reset; same-cycle read-after-write is resolved by the caller's bypass.
module leve2_regfile
  import leve2_pkg::*;
#(
  parameter int NUM_REG = 32,
  parameter int XLEN    = 64
) (
  input  logic            CLK,
  input  logic            we,
  input  logic [4:0]      waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [4:0]      raddr1,
  output logic [XLEN-1:0] rdata1,
  input  logic [4:0]      raddr2,
  output logic [XLEN-1:0] rdata2
);

  localparam int         AW   = $clog2(NUM_REG);
  localparam logic [5:0] NREG = 6'(NUM_REG);

  logic [XLEN-1:0] regs [NUM_REG];

  // Index is a real register only if non-zero and below NUM_REG; the range
  // guard also stops RV-E indices from aliasing onto low registers.
  function automatic logic valid_idx(input logic [4:0] idx);
    return (idx != 5'd0) && ({1'b0, idx} < NREG);
  endfunction

  // Synchronous write, silently dropping x0 and out-of-range targets.
  always_ff @(posedge CLK) begin
    if (we && valid_idx(waddr)) regs[waddr[AW-1:0]] <= wdata;
  end

  // Asynchronous reads with x0 / out-of-range forced to zero.
  always_comb begin
    rdata1 = valid_idx(raddr1) ? regs[raddr1[AW-1:0]] : '0;
    rdata2 = valid_idx(raddr2) ? regs[raddr2[AW-1:0]] : '0;
  end

endmodule

// File: rtl/leve2_regread.sv
// leve2_regread -- LEVE2 decode/operand-read stage between fetch and execute.
//
// Ports:
//   CLK, RST                 clock, synchronous active-high reset
//   I_VALID/I_READY          fetch handshake; I_PC, I_INSTR incoming instruction
//   FLUSH                    redirect: kill held and incoming instruction
//   O_VALID/O_READY          execute handshake
//   O_PC, O_INSTR            registered PC and instruction
//   O_RS1, O_RS2, O_IMM      operands and sign-extended immediate
//   O_ILLEGAL                rs1/rs2/rd index >= NUM_REG
//   EX_VALID/WE/LOAD/RD/DATA EX stage forwarding and load-use information
//   WB_WE/RD/DATA            write-back port (register file write + bypass)
module leve2_regread
  import leve2_pkg::*;
#(
  parameter int XLEN    = 64,
  parameter int NUM_REG = 32
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            I_VALID,
  output logic            I_READY,
  input  logic [XLEN-1:0] I_PC,
  input  logic [31:0]     I_INSTR,
  input  logic            FLUSH,
  output logic            O_VALID,
  input  logic            O_READY,
  output logic [XLEN-1:0] O_PC,
  output logic [31:0]     O_INSTR,
  output logic [XLEN-1:0] O_RS1,
  output logic [XLEN-1:0] O_RS2,
  output logic [XLEN-1:0] O_IMM,
  output logic            O_ILLEGAL,
  input  logic            EX_VALID,
  input  logic            EX_WE,
  input  logic            EX_LOAD,
  input  logic [4:0]      EX_RD,
  input  logic [XLEN-1:0] EX_DATA,
  input  logic            WB_WE,
  input  logic [4:0]      WB_RD,
  input  logic [XLEN-1:0] WB_DATA
);

  localparam logic [5:0] NREG = 6'(NUM_REG);

  logic [4:0]      rs1, rs2, rd;
  logic            hold, hazard, ex_fwd, illegal;
  logic [XLEN-1:0] rf_rs1, rf_rs2, op1, op2, imm;
  logic [63:0]     imm_full;

  assign rs1 = I_INSTR[19:15];
  assign rs2 = I_INSTR[24:20];
  assign rd  = I_INSTR[11:7];

  leve2_regfile #(
    .NUM_REG (NUM_REG),
    .XLEN    (XLEN)
  ) u_regfile (
    .CLK    (CLK),
    .we     (WB_WE),
    .waddr  (WB_RD),
    .wdata  (WB_DATA),
    .raddr1 (rs1),
    .rdata1 (rf_rs1),
    .raddr2 (rs2),
    .rdata2 (rf_rs2)
  );

  // Operand priority: x0, out-of-range, EX forward (non-load only), WB bypass,
  // then the array. EX is younger than WB, so it wins when both match.
  function automatic logic [XLEN-1:0] pick(
    input logic [4:0]      idx,
    input logic [XLEN-1:0] rf_val,
    input logic            ex_en,
    input logic [4:0]      ex_idx,
    input logic [XLEN-1:0] ex_val,
    input logic            wb_en,
    input logic [4:0]      wb_idx,
    input logic [XLEN-1:0] wb_val
  );
    if (idx == 5'd0 || {1'b0, idx} >= NREG) return '0;
    else if (ex_en && ex_idx == idx)        return ex_val;
    else if (wb_en && wb_idx == idx)        return wb_val;
    else                                    return rf_val;
  endfunction

  // Handshake, interlock and operand/immediate decode. The hazard compare
  // ignores instruction format on purpose: a spurious stall is harmless.
  always_comb begin
    hold     = O_VALID && !O_READY;
    hazard   = I_VALID && EX_VALID && EX_LOAD && EX_WE && (EX_RD != 5'd0) &&
               ((EX_RD == rs1) || (EX_RD == rs2));
    I_READY  = FLUSH || (!hold && !hazard);
    ex_fwd   = EX_VALID && EX_WE && !EX_LOAD;
    illegal  = ({1'b0, rs1} >= NREG) || ({1'b0, rs2} >= NREG) ||
               ({1'b0, rd} >= NREG);
    imm_full = imm_gen(I_INSTR, XLEN);
    imm      = imm_full[XLEN-1:0];
    op1      = pick(rs1, rf_rs1, ex_fwd, EX_RD, EX_DATA, WB_WE, WB_RD, WB_DATA);
    op2      = pick(rs2, rf_rs2, ex_fwd, EX_RD, EX_DATA, WB_WE, WB_RD, WB_DATA);
  end

  // Output register: flush > hold (with WB refresh of the held operands so
  // they never go stale) > load-use bubble > normal capture.
  always_ff @(posedge CLK) begin
    if (RST) begin
      O_VALID   <= 1'b0;
      O_PC      <= '0;
      O_INSTR   <= 32'd0;
      O_RS1     <= '0;
      O_RS2     <= '0;
      O_IMM     <= '0;
      O_ILLEGAL <= 1'b0;
    end else if (FLUSH) begin
      O_VALID <= 1'b0;
    end else if (hold) begin
      if (WB_WE && WB_RD != 5'd0 && WB_RD == O_INSTR[19:15]) O_RS1 <= WB_DATA;
      if (WB_WE && WB_RD != 5'd0 && WB_RD == O_INSTR[24:20]) O_RS2 <= WB_DATA;
    end else if (hazard) begin
      O_VALID <= 1'b0;
    end else begin
      O_VALID   <= I_VALID;
      O_PC      <= I_PC;
      O_INSTR   <= I_INSTR;
      O_RS1     <= op1;
      O_RS2     <= op2;
      O_IMM     <= imm;
      O_ILLEGAL <= illegal;
    end
  end

endmodule
